repsub_divider: RTL and testbench
=================================

Name: repsub_divider

Overview:
- Unsigned integer divider using repeated subtraction; the inverse of the team's repeated-addition multiplier datapath.
- Loads dividend then divisor over a shared data_in bus on consecutive cycles, like the multiplier's A/B load sequence.
- Subtracts the divisor from a remainder register while counting a quotient register, and contains its own control FSM.
- Sits beside the multiplier as the arithmetic-unit divide path.

Parameters:
WIDTH, 16, operand/quotient/remainder width in bits

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
start  input  1  begin operation; sampled only in IDLE
data_in  input  WIDTH  dividend in the start cycle, divisor in the following cycle
quotient  output  WIDTH  result quotient, valid when done=1 and held until next start
remainder  output  WIDTH  result remainder, valid when done=1 and held until next start
done  output  1  one-cycle pulse in DONE state
busy  output  1  high in every state except IDLE
dz_err  output  1  divisor was zero; held until next accepted start

Behaviour:
- Reset, sampled at clk edge with rst=1:
  - state=IDLE; quotient=0, remainder=0, divisor reg=0; done=0, busy=0, dz_err=0.
  - Reset mid-operation aborts immediately with the same values; there is no partial result.
- FSM states: IDLE, LDB, CHK, SUB, DONE.
- IDLE, start=1: remainder<=data_in (dividend), quotient<=0, dz_err<=0, next LDB. With start=0, stay and hold all outputs.
- LDB: divisor<=data_in; next CHK. start is ignored.
- CHK:
  - divisor==0: dz_err<=1, quotient=0, remainder=dividend; next DONE.
  - Otherwise next SUB.
- SUB, one compare per cycle:
  - remainder>=divisor: remainder<=remainder-divisor, quotient<=quotient+1; stay in SUB.
  - Otherwise next DONE.
- DONE: done=1 for exactly this cycle; next IDLE. A start in this cycle is ignored.
- Latency, with cycle 0 = start accepted:
  - Normal: done high in cycle q+4, where q is the quotient (q subtract cycles plus one terminating compare).
  - Divide-by-zero: done high in cycle 3.
- Arithmetic:
  - Compare and subtract are unsigned WIDTH bits; the subtraction never underflows because it is guarded by the compare.
  - Quotient cannot overflow: the maximum is 2^WIDTH-1, reached with divisor=1.
- start is ignored whenever busy=1; it is not queued.
- Outputs are registered, with no combinational path from inputs to outputs.

Decomposition:
- Shared package (arith_pkg): state enum type (IDLE, LDB, CHK, SUB, DONE) and the default WIDTH constant.
- One natural sub-module, repsub_div_dp, holds the datapath:
  - remainder, divisor and quotient registers;
  - the >= comparator and subtractor;
  - outputs ge and dz flags.
- The FSM lives in repsub_divider and drives the datapath load/decrement/increment enables, mirroring the multiplier's datapath/controller split.

Test Plan:
- Basic divide: reset; start with 100, then 7 → done in cycle 18, quotient=14, remainder=2, dz_err=0; outputs hold while IDLE.
- Dividend below divisor: 5 then 9 → done in cycle 4, quotient=0, remainder=5.
- Divide-by-zero: 42 then 0 → done in cycle 3, dz_err=1, quotient=0, remainder=42. A following 20/4 run clears dz_err and gives quotient=5, remainder=0.
- Max width: 0xFFFF then 1 → quotient=0xFFFF, remainder=0, done in cycle 65539. Also 0xFFFF then 0xFFFF → quotient=1, remainder=0, done in cycle 5.
- Abort and ignored start:
  - During SUB of 1000/3, pulse start=1 → ignored, busy stays 1.
  - Assert rst in cycle 10 → next cycle state IDLE, all outputs 0, no done pulse.
  - A new 9/2 run then gives quotient=4, remainder=1.
- Back-to-back: start asserted in the DONE cycle is ignored; start in the next IDLE cycle is accepted, with done pulses separated exactly as the latency formula predicts.

Source files
------------

// File: rtl/arith_pkg.sv
package arith_pkg;

  localparam int unsigned DEF_WIDTH = 16;

  typedef enum logic [2:0] {
    IDLE,
    LDB,
    CHK,
    SUB,
    DONE
  } state_t;

endpackage

// File: rtl/repsub_div_dp.sv
module repsub_div_dp
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load_a,
  input  logic             i_load_b,
  input  logic             i_step,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_ge,
  output logic             o_dz
);

  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_div;
  logic [WIDTH-1:0] r_quo;

  // Subtract is only enabled while r_rem >= r_div, so it never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rem <= '0;
      r_div <= '0;
      r_quo <= '0;
    end else begin
      if (i_load_a) begin
        r_rem <= i_data;
        r_quo <= '0;
      end
      if (i_load_b) begin
        r_div <= i_data;
      end
      if (i_step) begin
        r_rem <= r_rem - r_div;
        r_quo <= r_quo + WIDTH'(1);
      end
    end
  end

  assign o_ge        = (r_rem >= r_div);
  assign o_dz        = (r_div == '0);
  assign o_quotient  = r_quo;
  assign o_remainder = r_rem;

endmodule

// File: rtl/repsub_divider.sv
module repsub_divider
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done,
  output logic             busy,
  output logic             dz_err
);

  state_t r_state;
  state_t w_next;
  logic   w_load_a;
  logic   w_load_b;
  logic   w_step;
  logic   w_ge;
  logic   w_dz;
  logic   r_dz_err;

  repsub_div_dp #(
    .WIDTH(WIDTH)
  ) u_dp (
    .clk        (clk),
    .rst        (rst),
    .i_load_a   (w_load_a),
    .i_load_b   (w_load_b),
    .i_step     (w_step),
    .i_data     (data_in),
    .o_quotient (quotient),
    .o_remainder(remainder),
    .o_ge       (w_ge),
    .o_dz       (w_dz)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_load_a = 1'b0;
    w_load_b = 1'b0;
    w_step   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_load_a = 1'b1;
          w_next   = LDB;
        end
      end
      LDB: begin
        w_load_b = 1'b1;
        w_next   = CHK;
      end
      CHK: begin
        w_next = w_dz ? DONE : SUB;
      end
      SUB: begin
        if (w_ge) begin
          w_step = 1'b1;
        end else begin
          w_next = DONE;
        end
      end
      DONE: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dz_err <= 1'b0;
    end else if (r_state == IDLE && start) begin
      r_dz_err <= 1'b0;
    end else if (r_state == CHK && w_dz) begin
      r_dz_err <= 1'b1;
    end
  end

  // done/busy decode the state register directly, so no input reaches them combinationally.
  assign done   = (r_state == DONE);
  assign busy   = (r_state != IDLE);
  assign dz_err = r_dz_err;

endmodule

// File: tb/tb_repsub_divider.sv
module tb_repsub_divider;

  localparam int unsigned W = 16;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] data_in;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         done;
  logic         busy;
  logic         dz_err;

  int unsigned total;
  int unsigned bad;

  repsub_divider #(
    .WIDTH(W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .data_in  (data_in),
    .quotient (quotient),
    .remainder(remainder),
    .done     (done),
    .busy     (busy),
    .dz_err   (dz_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Call at a negedge: cycle 0 is the one where start is sampled; returns in cycle 1.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    start   = 1'b1;
    data_in = a;
    @(negedge clk);
    start   = 1'b0;
    data_in = b;
  endtask

  task automatic wait_done(input string tag, input int unsigned exp_lat);
    int unsigned c;
    c = 1;
    check({tag, "_busy1"}, 32'(busy), 32'd1);
    while (!done && c < exp_lat + 20) begin
      @(negedge clk);
      c++;
    end
    check({tag, "_lat"}, c, exp_lat);
  endtask

  task automatic run(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz,
                     input int unsigned lat);
    issue(a, b);
    wait_done(tag, lat);
    check({tag, "_q"}, 32'(quotient), 32'(eq));
    check({tag, "_r"}, 32'(remainder), 32'(er));
    check({tag, "_dz"}, 32'(dz_err), 32'(edz));
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_idle"}, 32'(busy), 32'd0);
    @(negedge clk);
    check({tag, "_hold_q"}, 32'(quotient), 32'(eq));
    check({tag, "_hold_r"}, 32'(remainder), 32'(er));
    check({tag, "_hold_dz"}, 32'(dz_err), 32'(edz));
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    rst     = 1'b1;
    start   = 1'b0;
    data_in = '0;
    repeat (3) @(negedge clk);
    check("rst_q", 32'(quotient), 32'd0);
    check("rst_r", 32'(remainder), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_dz", 32'(dz_err), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run("basic", 16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 18);
    run("small", 16'd5, 16'd9, 16'd0, 16'd5, 1'b0, 4);
    run("dz", 16'd42, 16'd0, 16'd0, 16'd42, 1'b1, 3);

    issue(16'd20, 16'd4);
    check("dz_clear", 32'(dz_err), 32'd0);
    wait_done("after_dz", 9);
    check("after_dz_q", 32'(quotient), 32'd5);
    check("after_dz_r", 32'(remainder), 32'd0);
    @(negedge clk);
    @(negedge clk);

    run("max1", 16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 1'b0, 65539);
    run("maxmax", 16'hFFFF, 16'hFFFF, 16'd1, 16'd0, 1'b0, 5);

    // Ignored start during SUB, then abort by reset.
    issue(16'd1000, 16'd3);
    repeat (4) @(negedge clk);
    start   = 1'b1;
    data_in = 16'd77;
    @(negedge clk);
    start = 1'b0;
    check("ign_busy", 32'(busy), 32'd1);
    check("ign_q", 32'(quotient), 32'd3);
    check("ign_r", 32'(remainder), 32'd991);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_q", 32'(quotient), 32'd0);
    check("abort_r", 32'(remainder), 32'd0);
    check("abort_dz", 32'(dz_err), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("abort_still_idle", 32'(busy), 32'd0);
    run("post_abort", 16'd9, 16'd2, 16'd4, 16'd1, 1'b0, 8);

    // Back-to-back: start in DONE ignored, start in following IDLE accepted.
    issue(16'd20, 16'd4);
    wait_done("b2b_a", 9);
    start   = 1'b1;
    data_in = 16'd50;
    @(negedge clk);
    check("b2b_done_start_ign", 32'(busy), 32'd0);
    check("b2b_a_q", 32'(quotient), 32'd5);
    issue(16'd50, 16'd7);
    wait_done("b2b_b", 11);
    check("b2b_b_q", 32'(quotient), 32'd7);
    check("b2b_b_r", 32'(remainder), 32'd1);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
